fast_circle_fetch: RTL and testbench
====================================

Name: fast_circle_fetch

Overview:
- Downstream consumer of sram_image in the Oriented FAST pipeline.
- For a requested centre pixel (cx, cy), issues 17 synchronous reads to the image SRAM: the centre pixel plus the 16-pixel Bresenham circle of radius 3.
- Presents all 17 pixels in parallel, with a one-cycle done pulse, to the FAST segment-test stage.
- Rejects centres whose circle would leave the image; never writes the SRAM.

Parameters:
- PIXEL_DEPTH, 8, bits per pixel; must match sram_image.
- X_MAX, 640, image width in pixels.
- Y_MAX, 480, image height in pixels.

Ports:
- clk  in  1  system clock; the same clock drives sram_image ramclk.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  request a fetch at (cx, cy); sampled only when busy=0.
- cx  in  $clog2(X_MAX)+1  centre x.
- cy  in  $clog2(Y_MAX)+1  centre y.
- busy  out  1  fetch in progress; start is ignored while high.
- done  out  1  one-cycle pulse: results valid.
- border  out  1  valid with done; 1 = centre rejected, no reads issued.
- center_pix  out  PIXEL_DEPTH  centre pixel.
- ring_pix  out  16*PIXEL_DEPTH  ring pixels; index i occupies bits [i*PIXEL_DEPTH +: PIXEL_DEPTH].
- x_addr  out  $clog2(X_MAX)+1  SRAM x address.
- y_addr  out  $clog2(Y_MAX)+1  SRAM y address.
- ren  out  1  SRAM read enable.
- rdat  in  PIXEL_DEPTH  SRAM read data, valid the cycle after ren/address.

Behaviour:
- Reset (async, n_rst=0): state IDLE; busy, done, border, ren = 0; x_addr, y_addr, center_pix, ring_pix = 0. A reset mid-fetch aborts immediately; there is no partial done.
- Read order, fixed:
  - index 0: centre.
  - ring 0..15, clockwise from top, offsets (dx,dy) = (0,-3)(1,-3)(2,-2)(3,-1)(3,0)(3,1)(2,2)(1,3)(0,3)(-1,3)(-2,2)(-3,1)(-3,0)(-3,-1)(-2,-2)(-1,-3).
- Bounds: centre is valid iff 3 <= cx <= X_MAX-4 and 3 <= cy <= Y_MAX-4. Address arithmetic is done in signed width+1 and never wraps. If X_MAX<7 or Y_MAX<7, every centre is border.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: busy=0. On start (edge E0), latch cx and cy.
    - Valid centre: go to ISSUE.
    - Invalid centre: go to DONE with border=1.
  - ISSUE: busy=1, ren=1, one read per cycle. Read k (k=0..16) is driven during the cycle after edge Ek, using a 5-bit read counter. After read 16 is issued, go to DRAIN.
  - Capture: rdat for read k is registered at edge E(k+2), into center_pix for k=0 and ring_pix[k-1] for k≥1. Captures overlap issue.
  - DRAIN: busy=1, ren=0. Captures the final read (ring 15) at E18, then goes to DONE.
  - DONE: done=1 for exactly one cycle; busy=0. Return to IDLE.
- Latency: valid fetch has done high in the cycle after E18 (18 clocks from start sample). Border fetch has done high in the cycle after E1, with border=1.
- Border case: ren never asserted; center_pix and ring_pix hold their previous values.
- border holds its value until the next done.
- Back-to-back: busy=0 in the DONE cycle, so a start sampled at that edge is accepted. Sustained rate is one fetch per 19 cycles.
- Start while busy=1: ignored entirely; the latched cx/cy are unchanged.
- x_addr and y_addr hold their last value when ren=0. Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- fast_pkg holds:
  - RING_N=16, RADIUS=3.
  - the signed offset constant arrays RING_DX and RING_DY.
  - the state enum typedef fetch_state_t {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module fast_ring_offset: combinational lookup from read index 0..16 to signed (dx,dy); index 0 maps to (0,0). It is reused later by the orientation stage.

Test Plan:
Common setup: X_MAX=Y_MAX=16, a sram_image model preloaded with pixel(x,y) = x + 16*y.
1. start at (8,8) → ren high for exactly 17 cycles. done 18 cycles after start, border=0. Expected: center_pix=136, ring0=88, ring4=139, ring8=184, ring12=133, ring2=(10,6)=106.
2. Corner limits: (3,3) and (12,12) → border=0. (3,3) gives center 51 and ring0=3; (12,12) gives center 204 and ring8=252. (13,12), (2,8) and (8,15) → done one cycle after start, border=1, ren never high, pixel outputs unchanged.
3. start pulsed at cycle 5 of a fetch at (8,8), with cx=4, cy=4 → ignored; the result matches scenario 1 and exactly one done is produced.
4. start held high continuously with (8,8) → done every 19 cycles with identical values, and no ren gap other than the 2-cycle drain/done.
5. n_rst low at cycle 9 of a fetch → busy, ren and outputs go to 0 asynchronously, with no done. A subsequent fetch at (5,10) gives center 165 and ring0 (5,7)=117.

Source files
------------

// File: rtl/fast_circle_fetch_pkg.sv
// Shared constants, ring offset tables and FSM state type for the FAST
// circle fetch and the later orientation stage.
package fast_pkg;

  localparam int RING_N = 16;
  localparam int RADIUS = 3;

  // Bresenham radius-3 circle, clockwise starting at the top pixel.
  localparam logic signed [2:0] RING_DX [RING_N] = '{
    3'sd0, 3'sd1, 3'sd2, 3'sd3, 3'sd3, 3'sd3, 3'sd2, 3'sd1,
    3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
  };
  localparam logic signed [2:0] RING_DY [RING_N] = '{
    -3'sd3, -3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd3,
    3'sd3, 3'sd3, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd3
  };

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fetch_state_t;

endpackage

// File: rtl/fast_circle_fetch_ring_offset.sv
// Maps a read index (0 = centre, 1..16 = ring 0..15) to its signed
// (dx, dy) offset from the centre pixel.
module fast_ring_offset
  import fast_pkg::*;
(
  input  logic [4:0]        i_idx,
  output logic signed [2:0] o_dx,
  output logic signed [2:0] o_dy
);

  logic [4:0] w_sel;

  assign w_sel = i_idx - 5'd1;

  // Offset lookup; index 0 and out-of-range indices map to the centre.
  always_comb begin
    o_dx = 3'sd0;
    o_dy = 3'sd0;
    if ((i_idx >= 5'd1) && (i_idx <= 5'd16)) begin
      o_dx = RING_DX[w_sel[3:0]];
      o_dy = RING_DY[w_sel[3:0]];
    end else begin
      o_dx = 3'sd0;
      o_dy = 3'sd0;
    end
  end

endmodule

// File: rtl/fast_circle_fetch.sv
// Fetches the centre pixel and its 16-pixel radius-3 ring from the image
// SRAM, one read per clock, and presents them in parallel with a done pulse.
module fast_circle_fetch
  import fast_pkg::*;
#(
  parameter int PIXEL_DEPTH = 8,
  parameter int X_MAX       = 640,
  parameter int Y_MAX       = 480,
  localparam int XW         = $clog2(X_MAX) + 1,
  localparam int YW         = $clog2(Y_MAX) + 1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic [XW-1:0]               cx,
  input  logic [YW-1:0]               cy,
  output logic                        busy,
  output logic                        done,
  output logic                        border,
  output logic [PIXEL_DEPTH-1:0]      center_pix,
  output logic [16*PIXEL_DEPTH-1:0]   ring_pix,
  output logic [XW-1:0]               x_addr,
  output logic [YW-1:0]               y_addr,
  output logic                        ren,
  input  logic [PIXEL_DEPTH-1:0]      rdat
);

  localparam bit            GEOM_OK = (X_MAX >= 7) && (Y_MAX >= 7);
  localparam logic [XW:0]   X_LO    = (XW+1)'(RADIUS);
  localparam logic [XW:0]   X_HI    = (XW+1)'(X_MAX - 1 - RADIUS);
  localparam logic [YW:0]   Y_LO    = (YW+1)'(RADIUS);
  localparam logic [YW:0]   Y_HI    = (YW+1)'(Y_MAX - 1 - RADIUS);

  fetch_state_t      r_state, w_next_state;
  logic [4:0]        r_cnt, w_next_cnt;
  logic [XW-1:0]     r_cx, w_base_x;
  logic [YW-1:0]     r_cy, w_base_y;
  logic              r_bpend;
  logic              r_rd_v;
  logic [4:0]        r_rd_idx;
  logic              w_accept, w_valid_c;
  logic signed [2:0] w_dx, w_dy;
  logic signed [XW:0] w_sx;
  logic signed [YW:0] w_sy;

  assign w_valid_c = GEOM_OK &&
                     ({1'b0, cx} >= X_LO) && ({1'b0, cx} <= X_HI) &&
                     ({1'b0, cy} >= Y_LO) && ({1'b0, cy} <= Y_HI);
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));

  // The first read uses the incoming centre, later reads the latched one.
  assign w_base_x = (r_state == ISSUE) ? r_cx : cx;
  assign w_base_y = (r_state == ISSUE) ? r_cy : cy;

  fast_ring_offset u_offset (
    .i_idx (w_next_cnt),
    .o_dx  (w_dx),
    .o_dy  (w_dy)
  );

  // Signed one-bit-wider sums; a valid centre keeps every address in range.
  assign w_sx = $signed({1'b0, w_base_x}) + $signed({{(XW-2){w_dx[2]}}, w_dx});
  assign w_sy = $signed({1'b0, w_base_y}) + $signed({{(YW-2){w_dy[2]}}, w_dy});

  // Next-state and read-counter logic; rejected centres pass through DRAIN
  // so done lands one cycle after the accepting edge.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_next_cnt   = 5'd0;
          w_next_state = w_valid_c ? ISSUE : DRAIN;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE: begin
        if (r_cnt == 5'd16) begin
          w_next_state = DRAIN;
        end else begin
          w_next_cnt = r_cnt + 5'd1;
        end
      end
      DRAIN:   w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // State, address, control and capture registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_bpend    <= 1'b0;
      r_rd_v     <= 1'b0;
      r_rd_idx   <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      border     <= 1'b0;
      ren        <= 1'b0;
      x_addr     <= '0;
      y_addr     <= '0;
      center_pix <= '0;
      ring_pix   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_cx    <= cx;
        r_cy    <= cy;
        r_bpend <= !w_valid_c;
      end
      ren  <= (w_next_state == ISSUE);
      busy <= (w_next_state == ISSUE) || (w_next_state == DRAIN);
      done <= (w_next_state == DONE);
      if (w_next_state == DONE) begin
        border <= r_bpend;
      end
      if (w_next_state == ISSUE) begin
        x_addr <= w_sx[XW-1:0];
        y_addr <= w_sy[YW-1:0];
      end
      // SRAM data returns one cycle after the read, so track which slot it fills.
      r_rd_v   <= ren;
      r_rd_idx <= r_cnt;
      if (r_rd_v) begin
        if (r_rd_idx == 5'd0) begin
          center_pix <= rdat;
        end
        for (int i = 0; i < RING_N; i++) begin
          if (r_rd_idx == 5'(i + 1)) begin
            ring_pix[i*PIXEL_DEPTH +: PIXEL_DEPTH] <= rdat;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fast_circle_fetch.sv
// Self-checking bench: 16x16 image with pixel(x,y) = x + 16*y, table and
// random fetches compared against a geometric reference model.
module tb_fast_circle_fetch;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [4:0]   cx, cy;
  logic         busy, done, border, ren;
  logic [7:0]   center_pix;
  logic [127:0] ring_pix;
  logic [4:0]   x_addr, y_addr;
  logic [7:0]   rdat = 8'd0;

  int checks   = 0;
  int failures = 0;

  int DXS [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int DYS [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic [7:0]   exp_center = 8'd0;
  logic [127:0] exp_ring   = 128'd0;

  typedef struct {
    int x;
    int y;
    bit bd;
  } vec_t;

  vec_t vecs [8];

  fast_circle_fetch #(.PIXEL_DEPTH(8), .X_MAX(16), .Y_MAX(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .cx         (cx),
    .cy         (cy),
    .busy       (busy),
    .done       (done),
    .border     (border),
    .center_pix (center_pix),
    .ring_pix   (ring_pix),
    .x_addr     (x_addr),
    .y_addr     (y_addr),
    .ren        (ren),
    .rdat       (rdat)
  );

  always #5 clk = ~clk;

  // Image SRAM model: one-cycle synchronous read.
  always @(posedge clk) begin
    if (ren) rdat <= 8'((int'(x_addr) + 16 * int'(y_addr)) % 256);
  end

  function automatic logic [7:0] pix(int x, int y);
    return 8'((x + 16 * y) % 256);
  endfunction

  function automatic logic [127:0] ring_model(int x, int y);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = pix(x + DXS[i], y + DYS[i]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic run_fetch(input int x, input int y, input bit bd);
    int lat, rens;
    if (!bd) begin
      exp_center = pix(x, y);
      exp_ring   = ring_model(x, y);
    end
    @(negedge clk);
    cx = 5'(x); cy = 5'(y); start = 1'b1;
    lat = 0; rens = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (ren) rens++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("latency(%0d,%0d)", x, y), lat, bd ? 2 : 19);
    chk($sformatf("ren_cycles(%0d,%0d)", x, y), rens, bd ? 0 : 17);
    chk($sformatf("border(%0d,%0d)", x, y), border, bd);
    chk($sformatf("busy_at_done(%0d,%0d)", x, y), busy, 0);
    chk($sformatf("center(%0d,%0d)", x, y), center_pix, exp_center);
    chk($sformatf("ring(%0d,%0d)", x, y), ring_pix, exp_ring);
    @(negedge clk);
    chk($sformatf("done_pulse(%0d,%0d)", x, y), {border, done}, {bd, 1'b0});
  endtask

  initial begin
    int dones, first, rbad, x, y;
    bit bd;

    n_rst = 1'b0; start = 1'b0; cx = 5'd0; cy = 5'd0;
    #1;
    chk("reset_ctrl", {busy, done, border, ren}, 4'b0000);
    chk("reset_addr", {x_addr, y_addr}, 10'd0);
    chk("reset_pix", {center_pix, ring_pix}, 136'd0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;

    vecs[0] = '{8, 8, 1'b0};   vecs[1] = '{3, 3, 1'b0};
    vecs[2] = '{12, 12, 1'b0}; vecs[3] = '{13, 12, 1'b1};
    vecs[4] = '{2, 8, 1'b1};   vecs[5] = '{8, 15, 1'b1};
    vecs[6] = '{12, 3, 1'b0};  vecs[7] = '{3, 2, 1'b1};

    run_fetch(8, 8, 1'b0);
    chk("s1_center", center_pix, 8'd136);
    chk("s1_ring0", ring_pix[0 +: 8], 8'd88);
    chk("s1_ring2", ring_pix[16 +: 8], 8'd106);
    chk("s1_ring4", ring_pix[32 +: 8], 8'd139);
    chk("s1_ring8", ring_pix[64 +: 8], 8'd184);
    chk("s1_ring12", ring_pix[96 +: 8], 8'd133);

    for (int v = 0; v < 8; v++) run_fetch(vecs[v].x, vecs[v].y, vecs[v].bd);

    // Start pulsed mid-fetch with a different centre must be ignored.
    @(negedge clk);
    cx = 5'd8; cy = 5'd8; start = 1'b1;
    exp_center = pix(8, 8); exp_ring = ring_model(8, 8);
    dones = 0; first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin cx = 5'd4; cy = 5'd4; start = 1'b1; end
      if (n == 6) start = 1'b0;
      if (done) begin
        dones++;
        if (first == 0) first = n;
      end
    end
    chk("busy_start_dones", dones, 1);
    chk("busy_start_latency", first, 19);
    chk("busy_start_center", center_pix, exp_center);
    chk("busy_start_ring", ring_pix, exp_ring);

    // Start held high: one fetch every 19 cycles, 2-cycle ren gap.
    @(negedge clk);
    cx = 5'd8; cy = 5'd8; start = 1'b1;
    dones = 0; rbad = 0;
    for (int n = 1; n <= 57; n++) begin
      @(negedge clk);
      if (ren !== !((n % 19 == 18) || (n % 19 == 0))) rbad++;
      if (done) begin
        dones++;
        chk($sformatf("held_done_pos%0d", dones), n, 19 * dones);
        chk($sformatf("held_ring%0d", dones), {center_pix, ring_pix}, {exp_center, exp_ring});
      end
      if (n == 57) start = 1'b0;
    end
    chk("held_dones", dones, 3);
    chk("held_ren_pattern", rbad, 0);
    @(negedge clk);
    chk("held_stopped", {busy, ren}, 2'b00);

    // Asynchronous reset in the middle of a fetch.
    @(negedge clk);
    cx = 5'd8; cy = 5'd8; start = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    n_rst = 1'b0;
    #1;
    chk("abort_ctrl", {busy, done, border, ren}, 4'b0000);
    chk("abort_addr", {x_addr, y_addr}, 10'd0);
    chk("abort_pix", {center_pix, ring_pix}, 136'd0);
    exp_center = 8'd0; exp_ring = 128'd0;
    dones = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_rst = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_fetch(5, 10, 1'b0);
    chk("s5_center", center_pix, 8'd165);
    chk("s5_ring0", ring_pix[0 +: 8], 8'd117);

    // Random centres over the whole 5-bit range.
    for (int r = 0; r < 24; r++) begin
      x  = $urandom_range(0, 31);
      y  = $urandom_range(0, 31);
      bd = !((x >= 3) && (x <= 12) && (y >= 3) && (y <= 12));
      run_fetch(x, y, bd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
